// File: rtl/param_data_memory.sv
// Single-port synchronous data RAM with a post-reset clear sequencer,
// registered write-first read port and zero-returning out-of-range accesses.
module param_data_memory #(
  parameter int              DW        = 4,
  parameter int              AW        = 4,
  parameter int              DEPTH     = 16,
  parameter logic [DW-1:0]   CLEAR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] data_in,
  output logic [DW-1:0] data_out,
  output logic          busy
);

  localparam int            IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IW-1:0] LAST      = IW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(DEPTH);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [IW-1:0] cnt;
  logic [DW-1:0] mem [DEPTH];

  logic          in_range;
  logic [IW-1:0] idx;
  logic          mem_we;
  logic [IW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  function automatic logic addr_in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_EXT;
  endfunction

  assign in_range = addr_in_range(addr);
  assign idx      = addr[IW-1:0];

  // State register and clear counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state == CLEAR) cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    if (state == CLEAR && cnt == LAST) state_nxt = RUN;
  end

  // While clearing, the array write port belongs to the sequencer; rst blocks all writes
  always_comb begin
    busy      = (state == CLEAR);
    mem_we    = 1'b0;
    mem_waddr = cnt;
    mem_wdata = CLEAR_VAL;
    if (!rst) begin
      if (state == CLEAR) begin
        mem_we = 1'b1;
      end else if (we && in_range) begin
        mem_we    = 1'b1;
        mem_waddr = idx;
        mem_wdata = data_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Registered read, write-first on a same-address write
  always_ff @(posedge clk) begin
    if (rst || state == CLEAR || !in_range) data_out <= '0;
    else if (we)                            data_out <= data_in;
    else                                    data_out <= mem[idx];
  end

endmodule

// File: tb/tb_param_data_memory.sv
// Bench for param_data_memory: a default instance and a DW=8/AW=5/DEPTH=20
// instance, each checked every cycle against a word-level model.
module tb_param_data_memory;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_s  [2];
  logic       we_s   [2];
  logic [4:0] addr_s [2];
  logic [7:0] din_s  [2];
  logic [3:0] dout0;
  logic [7:0] dout1;
  logic       busy0, busy1;

  int checks   = 0;
  int failures = 0;

  logic [7:0] mm [2][32];
  int         left [2]    = '{0, 0};
  logic [7:0] eo   [2]    = '{8'h00, 8'h00};
  int         depth_k [2] = '{16, 20};
  logic [7:0] clr_k   [2] = '{8'h00, 8'hA5};
  bit         armed = 1'b0;

  param_data_memory u0 (
    .clk(clk), .rst(rst_s[0]), .we(we_s[0]), .addr(addr_s[0][3:0]),
    .data_in(din_s[0][3:0]), .data_out(dout0), .busy(busy0)
  );

  param_data_memory #(.DW(8), .AW(5), .DEPTH(20), .CLEAR_VAL(8'hA5)) u1 (
    .clk(clk), .rst(rst_s[1]), .we(we_s[1]), .addr(addr_s[1]),
    .data_in(din_s[1]), .data_out(dout1), .busy(busy1)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: reset reloads a "words left to clear" count; each clear edge fills the next word
  task automatic model_edge(input int k);
    logic [7:0] a, d;
    a = (k == 0) ? {4'b0, addr_s[k][3:0]} : {3'b0, addr_s[k]};
    d = (k == 0) ? {4'b0, din_s[k][3:0]}  : din_s[k];
    if (rst_s[k]) begin
      eo[k]   = 8'h00;
      left[k] = depth_k[k];
    end else if (left[k] > 0) begin
      mm[k][depth_k[k] - left[k]] = clr_k[k];
      left[k]--;
      eo[k] = 8'h00;
    end else if (int'(a) < depth_k[k]) begin
      eo[k] = we_s[k] ? d : mm[k][a];
      if (we_s[k]) mm[k][a] = d;
    end else begin
      eo[k] = 8'h00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
  endtask

  initial forever begin
    @(negedge clk);
    if (armed) begin
      check("busy0", {7'b0, busy0}, {7'b0, (left[0] > 0)});
      check("dout0", {4'b0, dout0}, eo[0]);
      check("busy1", {7'b0, busy1}, {7'b0, (left[1] > 0)});
      check("dout1", dout1, eo[1]);
    end
  end

  function automatic logic dut_busy(input int k);
    return (k == 0) ? busy0 : busy1;
  endfunction

  function automatic logic [7:0] dut_out(input int k);
    return (k == 0) ? {4'b0, dout0} : dout1;
  endfunction

  task automatic wait_clear(input int k, output int n);
    n = 0;
    while (dut_busy(k) && n < 60) begin
      tick();
      n++;
    end
  endtask

  task automatic rd(input int k, input logic [4:0] a, input logic [7:0] exp, input string nm);
    we_s[k]   = 1'b0;
    addr_s[k] = a;
    tick();
    check(nm, dut_out(k), exp);
  endtask

  task automatic wr(input int k, input logic [4:0] a, input logic [7:0] d);
    we_s[k]   = 1'b1;
    addr_s[k] = a;
    din_s[k]  = d;
    tick();
    we_s[k]   = 1'b0;
  endtask

  initial begin
    int n;
    for (int k = 0; k < 2; k++) begin
      rst_s[k] = 1'b1; we_s[k] = 1'b0; addr_s[k] = '0; din_s[k] = '0;
    end
    tick();
    armed = 1'b1;
    tick();
    check("reset_busy0", {7'b0, busy0}, 8'h01);
    check("reset_dout0", {4'b0, dout0}, 8'h00);

    // First clear, with a write attempt on clear cycle 5
    rst_s[0] = 1'b0;
    n = 0;
    while (busy0 && n < 60) begin
      if (n == 5) begin we_s[0] = 1'b1; addr_s[0] = 5'd2; din_s[0] = 8'd15; end
      else        begin we_s[0] = 1'b0; addr_s[0] = 5'd0; end
      tick();
      n++;
    end
    we_s[0] = 1'b0;
    check("clear_len0", 8'(n), 8'd16);
    for (int i = 0; i < 16; i++) rd(0, 5'(i), 8'h00, "cleared_word");

    wr(0, 5'd5, 8'd7);
    rd(0, 5'd5, 8'd7, "read_7");
    wr(0, 5'd5, 8'd12);
    rd(0, 5'd5, 8'd12, "read_12");
    rd(0, 5'd4, 8'd0, "neighbour_4");
    rd(0, 5'd6, 8'd0, "neighbour_6");
    rd(0, 5'd2, 8'd0, "blocked_write");

    wr(0, 5'd3, 8'd9);
    check("bypass_same_edge", {4'b0, dout0}, 8'd9);
    rd(0, 5'd3, 8'd9, "bypass_hold");

    // Reset in RUN
    wr(0, 5'd1, 8'd5);
    rd(0, 5'd1, 8'd5, "pre_reset_1");
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0;
    wait_clear(0, n);
    check("clear_len_run_reset", 8'(n), 8'd16);
    rd(0, 5'd1, 8'd0, "after_reset_1");
    rd(0, 5'd3, 8'd0, "after_reset_3");

    // Reset mid-clear at cycle 8, with X on we/addr early in the clear
    wr(0, 5'd7, 8'd6);
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i >= 1 && i <= 4) begin we_s[0] = 1'bx; addr_s[0] = 'x; din_s[0] = 8'hFF; end
      else                  begin we_s[0] = 1'b0; addr_s[0] = 5'd0; end
      tick();
    end
    we_s[0] = 1'b0; addr_s[0] = 5'd0;
    rst_s[0] = 1'b1;
    tick();
    rst_s[0] = 1'b0;
    wait_clear(0, n);
    check("clear_len_mid_reset", 8'(n), 8'd16);
    rd(0, 5'd7, 8'd0, "after_mid_reset_7");
    rd(0, 5'd0, 8'd0, "after_x_0");

    // Parametric instance
    rst_s[0] = 1'b1;
    rst_s[1] = 1'b0;
    wait_clear(1, n);
    check("clear_len1", 8'(n), 8'd20);
    rd(1, 5'd19, 8'hA5, "p_addr19");
    rd(1, 5'd0, 8'hA5, "p_addr0");
    wr(1, 5'd25, 8'h3C);
    check("p_oor_write_out", dout1, 8'h00);
    rd(1, 5'd25, 8'h00, "p_oor_read");
    rd(1, 5'd19, 8'hA5, "p_addr19_kept");
    rd(1, 5'd20, 8'h00, "p_addr20");
    wr(1, 5'd0, 8'h3C);
    rd(1, 5'd0, 8'h3C, "p_write0");

    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/param_data_memory.md
Name: param_data_memory

Overview:
- Next-generation CPU data memory: single-port synchronous RAM, parametrised in data width and depth.
- Adds a hardware clear sequencer that zero-fills (or CLEAR_VAL-fills) every word after reset, with a `busy` flag.
- Adds a registered read with write-first bypass and defined out-of-range handling.
- Sits between the CPU load/store datapath and the register file; defaults reproduce the existing 4-bit × 16-word map.

Parameters:
- DW, 4, data word width in bits (≥1).
- AW, 4, address width in bits (≥1).
- DEPTH, 16, number of implemented words; 1 ≤ DEPTH ≤ 2^AW.
- CLEAR_VAL, 0, DW-bit value written to every word by the clear sequencer.

Ports:
- clk  in  1  rising-edge clock, sole clock domain.
- rst  in  1  synchronous active-high reset.
- we  in  1  write enable, sampled on the rising clk edge.
- addr  in  AW  word address for both read and write.
- data_in  in  DW  write data.
- data_out  out  DW  registered read data.
- busy  out  1  high while the clear sequencer runs; CPU must stall.

Behaviour:
- Reset is synchronous, active-high, and single-clock. On any clk edge with rst=1:
  - data_out <= 0, busy <= 1, clear counter <= 0, FSM <= CLEAR.
  - Array contents are not touched by rst itself.
- FSM states: CLEAR, RUN.
- CLEAR:
  - Each cycle, mem[cnt] <= CLEAR_VAL and cnt <= cnt+1.
  - When cnt == DEPTH-1, that word is written and FSM moves to RUN; busy drops to 0 on the same edge.
  - CLEAR takes exactly DEPTH cycles; the first cycle after rst deasserts is write index 0.
  - busy=1 for DEPTH cycles after the rst-release edge.
- During CLEAR:
  - `we` is ignored; no user write reaches the array.
  - data_out holds 0; `addr` is ignored.
- RUN, write:
  - If we=1 and addr < DEPTH, mem[addr] <= data_in at the edge.
  - If addr ≥ DEPTH, the write is silently dropped.
- RUN, read:
  - Every edge, data_out <= mem[addr] (1-cycle latency); data_out is valid the cycle after addr is presented.
  - Read-during-write to the same address is write-first: data_out <= data_in on that edge.
  - If addr ≥ DEPTH, data_out <= 0.
- Reset mid-CLEAR: the counter restarts from 0 and the full DEPTH-cycle clear reruns.
- Reset in RUN: re-enters CLEAR; all contents end at CLEAR_VAL.
- rst held high for multiple cycles: state stays at the reset values; no array writes occur.
- Counter is wide enough for DEPTH-1 and never wraps past DEPTH-1.
- X on we/addr during CLEAR must not corrupt the array.

Test Plan:
- Clear sequence (defaults DW=4, AW=4, DEPTH=16, CLEAR_VAL=0):
  - Stimulus: rst=1 for 2 cycles, then 0.
  - Required: busy=1 for exactly 16 cycles, then 0.
  - Required: reading addr 0..15 afterwards gives data_out=0 each, one cycle after addr.
- Basic write/read:
  - Stimulus: write 7 to addr 5, then read addr 5.
  - Required: data_out=7 one cycle later.
  - Stimulus: overwrite with 12, then read.
  - Required: data_out=12; addr 4 and addr 6 still read 0.
- Write-first bypass:
  - Stimulus: we=1, addr=3, data_in=9 in one cycle.
  - Required: data_out=9 on that same edge.
  - Stimulus: next cycle we=0, addr=3.
  - Required: data_out stays 9.
- Writes blocked while busy:
  - Stimulus: during CLEAR cycle 5, drive we=1, addr=2, data_in=15.
  - Required: after busy=0, addr 2 reads 0.
- Reset mid-clear and reset in RUN:
  - Stimulus: assert rst at CLEAR cycle 8, then release.
  - Required: busy high a full 16 more cycles.
  - Stimulus: write 5 to addr 1 in RUN, pulse rst.
  - Required: addr 1 reads 0 after the clear.
- Parametric/out-of-range (DW=8, AW=5, DEPTH=20, CLEAR_VAL=8'hA5):
  - Required: busy lasts 20 cycles; addr 19 reads A5.
  - Stimulus: write 8'h3C to addr 25.
  - Required: write dropped; reading addr 25 gives 0; addr 19 is still A5.
